bp_hazard_ctrl: RTL

BP_HAZARD_CTRL -- requirements
Module: bp_hazard_ctrl

---
 rtl/bp_hazard_ctrl.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/bp_hazard_ctrl.sv
// ----------------------------------------------------------------------------
// bp_hazard_ctrl
//
// Direct-mapped branch target buffer with 2-bit saturating counters, combined
// with the EX-stage hazard unit of an in-order pipeline. It does three things:
//   * Prediction: combinational lookup at fetch.
//   * Correction: a combinational redirect when EX disagrees with the
//     prediction the instruction carried down the pipe.
//   * Load-use detection: a one-bubble stall.
// It also keeps saturating branch and mispredict statistics.
//
// Ports
//   clk, rst_n                     clock, asynchronous active-low reset
//   if_pc                          fetch PC
//   if_pred_taken, if_pred_target  fetch prediction
//   id_ra1, id_ra2                 ID source registers
//   ex_valid                       EX holds a real instruction
//   ex_is_branch/jump/load         EX instruction class
//   ex_wa3, ex_pc                  EX destination register and PC
//   ex_taken, ex_target            resolved outcome
//   ex_pred_taken/target           prediction made at fetch for this inst
//   bp_clear                       invalidate all entries (fence.i)
//   redirect, redirect_pc          fetch correction
//   should_stall, flush_if_id,
//   flush_id_ex                    pipeline control
//   stat_branches, stat_mispredicts  saturating statistics
// ----------------------------------------------------------------------------
module bp_hazard_ctrl #(
  parameter int XLEN    = 32,
  parameter int ENTRIES = 64,
  parameter int STAT_W  = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [XLEN-1:0]   if_pc,
  output logic              if_pred_taken,
  output logic [XLEN-1:0]   if_pred_target,
  input  logic [4:0]        id_ra1,
  input  logic [4:0]        id_ra2,
  input  logic              ex_valid,
  input  logic              ex_is_branch,
  input  logic              ex_is_jump,
  input  logic              ex_is_load,
  input  logic [4:0]        ex_wa3,
  input  logic [XLEN-1:0]   ex_pc,
  input  logic              ex_taken,
  input  logic [XLEN-1:0]   ex_target,
  input  logic              ex_pred_taken,
  input  logic [XLEN-1:0]   ex_pred_target,
  input  logic              bp_clear,
  output logic              redirect,
  output logic [XLEN-1:0]   redirect_pc,
  output logic              should_stall,
  output logic              flush_if_id,
  output logic              flush_id_ex,
  output logic [STAT_W-1:0] stat_branches,
  output logic [STAT_W-1:0] stat_mispredicts
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = XLEN - IDX_W - 2;

  logic             valid_q [ENTRIES];
  logic [1:0]       ctr_q   [ENTRIES];
  logic [TAG_W-1:0] tag_q   [ENTRIES];
  logic [XLEN-1:0]  tgt_q   [ENTRIES];

  // Fetch lookup reads the registered array, so a write in the same cycle
  // is only visible from the next cycle on.
  logic [IDX_W-1:0] if_idx;
  logic [TAG_W-1:0] if_tag;
  logic             if_hit;

  assign if_idx         = if_pc[IDX_W+1:2];
  assign if_tag         = if_pc[XLEN-1:IDX_W+2];
  assign if_hit         = valid_q[if_idx] && (tag_q[if_idx] == if_tag);
  assign if_pred_taken  = if_hit && ctr_q[if_idx][1];
  assign if_pred_target = tgt_q[if_idx];

  // EX-side classification.
  logic [IDX_W-1:0] ex_idx;
  logic [TAG_W-1:0] ex_tag;
  logic             ex_tag_match;
  logic             ex_hit;
  logic             resolve;
  logic             resolve_mis;
  logic             nonbr_mis;
  logic             mispredict;
  logic             load_use;

  assign ex_idx       = ex_pc[IDX_W+1:2];
  assign ex_tag       = ex_pc[XLEN-1:IDX_W+2];
  assign ex_tag_match = (tag_q[ex_idx] == ex_tag);
  assign ex_hit       = valid_q[ex_idx] && ex_tag_match;
  assign resolve      = ex_valid && (ex_is_branch || ex_is_jump);

  assign resolve_mis  = resolve && ((ex_pred_taken != ex_taken) ||
                                    (ex_taken && (ex_pred_target != ex_target)));
  // A non-control instruction that was predicted taken means the BTB entry
  // is stale, e.g. code was overwritten.
  assign nonbr_mis    = ex_valid && !(ex_is_branch || ex_is_jump) && ex_pred_taken;
  assign mispredict   = resolve_mis || nonbr_mis;

  assign load_use     = ex_valid && ex_is_load && (ex_wa3 != 5'd0) &&
                        ((ex_wa3 == id_ra1) || (ex_wa3 == id_ra2));

  // Pipeline controls are forced low while reset is held. A mispredict
  // flushes the dependent instruction anyway, so it masks the stall.
  assign redirect     = rst_n && mispredict;
  assign redirect_pc  = ex_taken ? ex_target : ex_pc + XLEN'(4);
  assign flush_if_id  = rst_n && mispredict;
  assign flush_id_ex  = rst_n && (mispredict || load_use);
  assign should_stall = rst_n && load_use && !mispredict;

  // Valid bits and counters carry architectural meaning and are reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ENTRIES; i++) begin
        // NOTE: non-blocking assignments keep every read in this edge seeing pre-edge state.
        valid_q[i] <= 1'b0;
        ctr_q[i]   <= 2'b01;
      end
    end else if (bp_clear) begin
      for (int i = 0; i < ENTRIES; i++) valid_q[i] <= 1'b0;
    end else if (resolve) begin
      if (ex_hit) begin
        if (ex_taken) ctr_q[ex_idx] <= (ctr_q[ex_idx] == 2'b11) ? 2'b11 : ctr_q[ex_idx] + 2'b01;
        else          ctr_q[ex_idx] <= (ctr_q[ex_idx] == 2'b00) ? 2'b00 : ctr_q[ex_idx] - 2'b01;
      end else if (ex_taken) begin
        valid_q[ex_idx] <= 1'b1;
        ctr_q[ex_idx]   <= 2'b10;
      end
    end else if (nonbr_mis && ex_tag_match) begin
      valid_q[ex_idx] <= 1'b0;
    end
  end

  // NOTE: tag/target payload is not reset; it is never observed unless the valid bit is set.
  always_ff @(posedge clk) begin
    if (!bp_clear && resolve && ex_taken) begin
      tag_q[ex_idx] <= ex_tag;
      tgt_q[ex_idx] <= ex_target;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_branches    <= '0;
      stat_mispredicts <= '0;
    end else begin
      if (resolve && !(&stat_branches))
        stat_branches <= stat_branches + STAT_W'(1);
      if (mispredict && !(&stat_mispredicts))
        stat_mispredicts <= stat_mispredicts + STAT_W'(1);
    end
  end

endmodule
